axi4_sram_bist_mst: RTL and testbench

AXI4 master that exercises an AXI4 SRAM slave end to end. On a start pulse it fills a word-addressed region with a seeded pattern using fixed-length INCR write bursts. It then reads the region back in INCR read bursts and compares every beat. It drives the master side of the same AXI4 interface the SRAM slave responds on, and serves as a self-checking traffic source in block and SoC benches.

---
 rtl/axi4_sram_bist_mst.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_sram_bist_mst.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_bist_mst.sv
// AXI4 SRAM BIST master: writes a seeded word pattern over a region in INCR bursts,
// reads it back, and counts mismatching beats and error responses.
module axi4_sram_bist_mst #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           WORD_DEPTH = 512,
    parameter int unsigned           BURST_LEN  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    start_i,
    input  logic [31:0]             seed_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [15:0]             err_cnt_o,
    output logic [ADDR_WIDTH-1:0]   first_err_addr_o,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned SIZE    = $clog2(STRB_W);
    localparam int unsigned N_BURST = WORD_DEPTH / BURST_LEN;
    localparam int unsigned IDX_W   = $clog2(WORD_DEPTH + 1);
    localparam int unsigned BEAT_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         seed_q;
    logic [IDX_W-1:0]    word_q;
    logic [IDX_W-1:0]    burst_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                start_ok, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                last_beat, last_burst, wr_err, rd_err, err_ev;
    logic [ADDR_WIDTH-1:0] err_addr;
    logic                unused_id;

    // Upper half of a 64-bit word is the inverse of the lower half
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] seed,
                                                      input logic [IDX_W-1:0] idx);
        logic [31:0] lo;
        lo = seed + 32'(idx);
        return DATA_WIDTH'({~lo, lo});
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (ADDR_WIDTH'(idx) << SIZE);
    endfunction

    assign awid    = '0;
    assign awlen   = 8'(BURST_LEN - 1);
    assign awsize  = 3'(SIZE);
    assign awburst = 2'b01;
    assign wstrb   = '1;
    assign arid    = '0;
    assign arlen   = 8'(BURST_LEN - 1);
    assign arsize  = 3'(SIZE);
    assign arburst = 2'b01;
    assign unused_id = ^{bid, rid};

    assign start_ok   = (state_q == S_IDLE) && start_i;
    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign b_hs       = bready && bvalid;
    assign ar_hs      = arvalid && arready;
    assign r_hs       = rready && rvalid;
    assign last_beat  = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign last_burst = (burst_q == IDX_W'(N_BURST - 1));

    // A read beat with several faults still counts as a single error
    assign wr_err   = b_hs && (bresp != 2'b00);
    assign rd_err   = r_hs && ((rdata != pattern(seed_q, word_q)) || (rresp != 2'b00) ||
                               (rlast != last_beat));
    assign err_ev   = wr_err || rd_err;
    assign err_addr = wr_err ? awaddr : word_addr(word_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start_i) state_d = S_WR_ADDR;
            S_WR_ADDR: if (aw_hs) state_d = S_WR_DATA;
            S_WR_DATA: if (w_hs && last_beat) state_d = S_WR_RESP;
            S_WR_RESP: if (b_hs) state_d = last_burst ? S_RD_ADDR : S_WR_ADDR;
            S_RD_ADDR: if (ar_hs) state_d = S_RD_DATA;
            S_RD_DATA: if (r_hs && last_beat) state_d = last_burst ? S_DONE : S_RD_ADDR;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Channel controls are registered from the next state so valids never see ready
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            awvalid          <= 1'b0;
            wvalid           <= 1'b0;
            bready           <= 1'b0;
            arvalid          <= 1'b0;
            rready           <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            err_cnt_o        <= '0;
            first_err_addr_o <= '0;
            awaddr           <= '0;
            araddr           <= '0;
            wdata            <= '0;
            wlast            <= 1'b0;
            seed_q           <= '0;
            word_q           <= '0;
            burst_q          <= '0;
            beat_q           <= '0;
        end else begin
            awvalid <= (state_d == S_WR_ADDR);
            wvalid  <= (state_d == S_WR_DATA);
            bready  <= (state_d == S_WR_RESP);
            arvalid <= (state_d == S_RD_ADDR);
            rready  <= (state_d == S_RD_DATA);
            busy_o  <= (state_d != S_IDLE) && (state_d != S_DONE);
            done_o  <= (state_d == S_DONE);

            if (start_ok) begin
                seed_q           <= seed_i;
                word_q           <= '0;
                burst_q          <= '0;
                beat_q           <= '0;
                awaddr           <= BASE_ADDR;
                err_cnt_o        <= '0;
                first_err_addr_o <= '0;
                pass_o           <= 1'b0;
            end

            if (aw_hs) begin
                beat_q <= '0;
                wlast  <= (BURST_LEN == 1);
                wdata  <= pattern(seed_q, word_q);
            end

            if (w_hs) begin
                word_q <= word_q + IDX_W'(1);
                wdata  <= pattern(seed_q, word_q + IDX_W'(1));
                if (last_beat) begin
                    beat_q <= '0;
                    wlast  <= 1'b0;
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                    wlast  <= ((beat_q + BEAT_W'(1)) == BEAT_W'(BURST_LEN - 1));
                end
            end

            if (b_hs) begin
                if (last_burst) begin
                    burst_q <= '0;
                    word_q  <= '0;
                    araddr  <= BASE_ADDR;
                end else begin
                    burst_q <= burst_q + IDX_W'(1);
                    awaddr  <= word_addr(word_q);
                end
            end

            if (ar_hs) beat_q <= '0;

            if (r_hs) begin
                word_q <= word_q + IDX_W'(1);
                if (last_beat) begin
                    beat_q  <= '0;
                    burst_q <= burst_q + IDX_W'(1);
                    araddr  <= word_addr(word_q + IDX_W'(1));
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end

            if (err_ev) begin
                if (err_cnt_o == 16'd0)     first_err_addr_o <= err_addr;
                if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
            end

            if (state_d == S_DONE) pass_o <= (err_cnt_o == 16'd0) && !err_ev;
        end
    end

endmodule

// File: tb/tb_axi4_sram_bist_mst.sv
// Bench for axi4_sram_bist_mst: behavioural AXI4 SRAM slave with stall and fault
// injection, protocol monitor, and directed runs with hand-computed results.
module tb_axi4_sram_bist_mst;

    localparam int unsigned AW = 32, DW = 32, IW = 4, DEPTH = 512, BL = 4;
    localparam int unsigned MIN_BUSY = (DEPTH / BL) * (1 + BL + 1) + (DEPTH / BL) * (1 + BL);

    logic clk = 1'b0;
    logic rst_n;
    logic start_i;
    logic [31:0] seed_i;
    logic busy_o, done_o, pass_o;
    logic [15:0] err_cnt_o;
    logic [AW-1:0] first_err_addr_o;
    logic [IW-1:0] awid, bid, arid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst, bresp, rresp;
    logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] wstrb;

    logic [31:0] mem [DEPTH];
    int          viol;
    bit          stall;
    int          corrupt_word;
    logic [31:0] bresp_err_addr;
    bit          early_rlast;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    axi4_sram_bist_mst #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BASE_ADDR('0),
        .WORD_DEPTH(DEPTH), .BURST_LEN(BL)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
        .first_err_addr_o(first_err_addr_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int mem_bad(input logic [31:0] seed);
        int bad = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== seed + 32'(k)) bad++;
        return bad;
    endfunction

    // Slave + monitor: sample handshakes at negedge, update responses just after posedge
    initial begin : slave
        bit h_aw, h_w, h_b, h_ar, h_r, p_aw, p_w, p_ar, r_act, r_first, b_pend;
        logic [31:0] a_aw, a_ar, d_w, p_awaddr, p_araddr, p_wdata, b_addr, ex_aw, ex_ar;
        logic p_wlast;
        logic [8:0] wptr, rptr;
        int wcnt, rbeat, wbeat_m;
        {awready, wready, arready, bvalid, rvalid, rlast} = '0;
        bid = '0; rid = '0; bresp = '0; rresp = '0; rdata = '0;
        {p_aw, p_w, p_ar, r_act, r_first, b_pend} = '0;
        {p_awaddr, p_araddr, p_wdata, b_addr, ex_aw, ex_ar} = '0;
        p_wlast = 1'b0; wptr = '0; rptr = '0; wcnt = 0; rbeat = 0; wbeat_m = 0;
        forever begin
            @(negedge clk);
            h_aw = awvalid && awready;
            h_w  = wvalid && wready;
            h_b  = bvalid && bready;
            h_ar = arvalid && arready;
            h_r  = rvalid && rready;
            a_aw = awaddr; a_ar = araddr; d_w = wdata;
            if (rst_n) begin
                if (p_aw && (!awvalid || awaddr != p_awaddr)) viol++;
                if (p_w && (!wvalid || wdata != p_wdata || wlast != p_wlast)) viol++;
                if (p_ar && (!arvalid || araddr != p_araddr)) viol++;
                if (awvalid && (awlen != 8'd3 || awsize != 3'd2 || awburst != 2'b01 || awid != '0)) viol++;
                if (arvalid && (arlen != 8'd3 || arsize != 3'd2 || arburst != 2'b01 || arid != '0)) viol++;
                if (wvalid && wstrb != 4'hF) viol++;
                if (h_aw) begin
                    if (awaddr != ex_aw) viol++;
                    ex_aw = (ex_aw + 32'd16) & 32'h7FF;
                end
                if (h_ar) begin
                    if (araddr != ex_ar) viol++;
                    ex_ar = (ex_ar + 32'd16) & 32'h7FF;
                end
                if (h_w) begin
                    if (wlast != (wbeat_m == 3)) viol++;
                    wbeat_m = (wbeat_m + 1) % 4;
                end
                p_aw = awvalid && !awready; p_awaddr = awaddr;
                p_w  = wvalid && !wready;   p_wdata = wdata; p_wlast = wlast;
                p_ar = arvalid && !arready; p_araddr = araddr;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                {bvalid, rvalid, rlast, b_pend, r_act, p_aw, p_w, p_ar} = '0;
                wcnt = 0; wbeat_m = 0; ex_aw = '0; ex_ar = '0;
            end else begin
                if (h_aw) begin wptr = a_aw[10:2]; b_addr = a_aw; end
                if (h_w) begin
                    mem[wptr] = d_w; wptr++; wcnt++;
                    if (wcnt == 4) begin wcnt = 0; b_pend = 1'b1; end
                end
                if (h_b) bvalid = 1'b0;
                if (b_pend && !bvalid) begin
                    bvalid = 1'b1;
                    bresp  = (b_addr == bresp_err_addr) ? 2'b10 : 2'b00;
                    b_pend = 1'b0;
                end
                if (h_ar) begin rptr = a_ar[10:2]; rbeat = 0; r_act = 1'b1; r_first = (a_ar == 0); end
                if (h_r) begin
                    rvalid = 1'b0; rptr++; rbeat++;
                    if (rbeat == 4) r_act = 1'b0;
                end
                if (r_act && !rvalid && (!stall || $urandom_range(1, 0) == 1)) begin
                    rvalid = 1'b1;
                    rdata  = mem[rptr] ^ ((int'(rptr) == corrupt_word) ? 32'h1 : 32'h0);
                    rlast  = (rbeat == 3) || (early_rlast && r_first && rbeat == 2);
                    rresp  = 2'b00;
                end
            end
            awready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            wready  = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            arready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    task automatic run_bist(input string tag, input logic [31:0] seed, input int pulse_at,
                            input int exp_err, input logic exp_pass, input bit chk_first,
                            input logic [31:0] exp_first, input bit chk_len);
        int cyc, busy_cyc;
        @(negedge clk); seed_i = seed; start_i = 1'b1; viol = 0;
        @(negedge clk); start_i = 1'b0;
        chk({tag, "_start"}, 32'({busy_o, pass_o, err_cnt_o}), 32'({1'b1, 1'b0, 16'h0}));
        cyc = 0; busy_cyc = 0;
        while (!done_o && cyc < 20000) begin
            if (busy_o) busy_cyc++;
            if (cyc == pulse_at) begin start_i = 1'b1; seed_i = 32'hDEAD_BEEF; end
            else start_i = 1'b0;
            cyc++;
            @(negedge clk);
        end
        start_i = 1'b0;
        chk({tag, "_done"}, 32'(done_o), 32'd1);
        chk({tag, "_pass"}, 32'(pass_o), 32'(exp_pass));
        chk({tag, "_err"}, 32'(err_cnt_o), 32'(exp_err));
        if (chk_first) chk({tag, "_first"}, first_err_addr_o, exp_first);
        if (chk_len) chk({tag, "_len"}, 32'(busy_cyc), 32'(MIN_BUSY));
        chk({tag, "_proto"}, 32'(viol), 32'd0);
        chk({tag, "_mem"}, 32'(mem_bad(seed)), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'({done_o, busy_o, pass_o}), 32'({2'b00, exp_pass}));
    endtask

    initial begin : main
        int cyc;
        rst_n = 1'b1; start_i = 1'b0; seed_i = '0; viol = 0;
        stall = 1'b0; corrupt_word = -1; bresp_err_addr = 32'hFFFF_FFFF; early_rlast = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        chk("rst_status", 32'({busy_o, done_o, pass_o}), 32'd0);
        chk("rst_err", 32'(err_cnt_o), 32'd0);
        chk("rst_first", first_err_addr_o, 32'd0);
        #2 rst_n = 1'b1;

        run_bist("basic", 32'h0000_1000, -1, 0, 1'b1, 1'b1, 32'h0, 1'b1);
        stall = 1'b1;
        run_bist("stall", 32'hFFFF_FF00, -1, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        stall = 1'b0;
        corrupt_word = 37;
        run_bist("corrupt", 32'h0, -1, 1, 1'b0, 1'b1, 32'h94, 1'b1);
        corrupt_word = -1;
        bresp_err_addr = 32'h50;
        run_bist("bresp", 32'h0000_0055, -1, 1, 1'b0, 1'b1, 32'h50, 1'b1);
        bresp_err_addr = 32'hFFFF_FFFF;
        early_rlast = 1'b1;
        run_bist("rlast", 32'h0BAD_F00D, -1, 1, 1'b0, 1'b1, 32'h8, 1'b1);
        early_rlast = 1'b0;
        run_bist("busy_start", 32'hA5A5_0000, 300, 0, 1'b1, 1'b0, 32'h0, 1'b1);

        // Abandon a run in the middle of a write burst
        @(negedge clk); seed_i = 32'h0000_3333; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        cyc = 0;
        while (!wvalid && cyc < 50) begin cyc++; @(negedge clk); end
        chk("mid_wr_data", 32'(wvalid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready}), 32'd0);
        chk("mid_rst_status", 32'({busy_o, done_o, pass_o}), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run_bist("post_rst", 32'h0000_0077, -1, 0, 1'b1, 1'b1, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
